// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM and its ALU decoder.
// Define MULTICYCLE_CONTROL_JAL_EN to build in the JAL state and jal decoding.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ
`ifdef MULTICYCLE_CONTROL_JAL_EN
    ,S_JAL
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp/funct fields to an ALUControl code and flags unsupported funct3.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] ALUControl,
  output logic       funct3_illegal
);

  always_comb begin
    funct3_illegal = 1'b0;
    unique case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: funct3_illegal = 1'b0;
      default:                        funct3_illegal = 1'b1;
    endcase
  end

  always_comb begin
    ALUControl = ALUC_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUC_ADD;
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) distinguishes sub; addi with bit30 set stays add.
          3'b000:  ALUControl = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  ALUControl = ALUC_SLT;
          3'b110:  ALUControl = ALUC_OR;
          3'b111:  ALUControl = ALUC_AND;
          default: ALUControl = ALUC_ADD;
        endcase
      end
      default: ALUControl = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32 subset datapath (lw/sw/R/I/beq[/jal]).
// Build with MULTICYCLE_CONTROL_JAL_EN to enable jal; otherwise jal decodes as illegal.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       funct3_illegal;
  logic       op_legal;
  logic       instr_illegal;
  logic       pc_write, ir_write, reg_write, mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ: op_legal = 1'b1;
`ifdef MULTICYCLE_CONTROL_JAL_EN
      OP_JAL:                           op_legal = 1'b1;
`endif
      default:                          op_legal = 1'b0;
    endcase
  end

  // funct3 only selects an ALU op for R/I-type; other opcodes ignore it.
  assign instr_illegal = !op_legal || (((op == OP_R) || (op == OP_I)) && funct3_illegal);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (instr_illegal) state_d = S_FETCH;
        else begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_BEQ:       state_d = S_BEQ;
`ifdef MULTICYCLE_CONTROL_JAL_EN
            OP_JAL:       state_d = S_JAL;
`endif
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
`ifdef MULTICYCLE_CONTROL_JAL_EN
      S_JAL:      state_d = S_ALUWB;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA  = SRCA_RS1;
        alu_op   = ALUOP_SUB;
        pc_write = zero;
      end
`ifdef MULTICYCLE_CONTROL_JAL_EN
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp          (alu_op),
    .op5            (op[5]),
    .funct3         (funct3),
    .funct7b5       (funct7b5),
    .ALUControl     (ALUControl),
    .funct3_illegal (funct3_illegal)
  );

  // State is already FETCH during reset; only the side-effecting strobes need masking.
  assign PCWrite  = pc_write  & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign illegal  = (state_q == S_DECODE) & instr_illegal & ~reset;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 op  in  7  instruction opcode field, instr[6:0].
REQ-005 funct3  in  3  instruction funct3 field, instr[14:12].
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 zero  in  1  ALU zero flag from the current cycle.
REQ-008 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables.
REQ-009 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register.
REQ-011 ALUSrcB  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4.
REQ-012 ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
REQ-013 ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
REQ-014 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-015 illegal  out  1  one-cycle pulse in DECODE when op or funct3 is unsupported.

Function
REQ-016 The FSM SHALL be Moore with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-017 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE -> MEMADR for lw (0000011) and sw (0100011); EXECR for R-type (0110011); EXECI for I-type (0010011); BEQ for beq (1100011); JAL for jal (1101111); FETCH otherwise.
- MEMADR -> MEMREAD for lw, MEMWRITE for sw.
- MEMREAD -> MEMWB.
- EXECR and EXECI -> ALUWB.
- JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
REQ-018 Per-state outputs (unlisted outputs are 0):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=zero.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1.
REQ-019 ALUControl decoding:
- ALUOp=add -> 000; ALUOp=sub -> 001.
- ALUOp=funct, funct3=000 -> 001 when op[5] and funct7b5 are both 1, else 000.
- ALUOp=funct, funct3 010 -> 101; 110 -> 011; 111 -> 010.
- Any other funct3 -> 000, and illegal SHALL pulse in DECODE.
REQ-020 ImmSrc SHALL be combinational from op in every state: lw/I-type -> 00, sw -> 01, beq -> 10, jal -> 11, others -> 00.
REQ-021 An instruction SHALL take: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles; illegal 2 cycles.
REQ-022 op, funct3 and funct7b5 SHALL be sampled only in DECODE, EXECR, EXECI and MEMADR; changes to them in other states SHALL have no effect.

Reset
REQ-023 Asserting reset SHALL force state to FETCH immediately, including mid-instruction.
REQ-024 While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and illegal SHALL be 0; all other outputs SHALL show their FETCH values.
REQ-025 The first rising clk edge after reset deasserts SHALL execute FETCH.

Configuration
REQ-026 Macro MULTICYCLE_CONTROL_JAL_EN:
- Defined: the JAL state and jal decoding SHALL be present.
- Undefined: opcode 1101111 SHALL be illegal (DECODE -> FETCH, illegal pulses) and the JAL state SHALL not exist.

Structure
REQ-027 Shared package ctrl_pkg SHALL hold the state enum, opcode constants, ALUOp codes, ALUControl codes and the ALUSrcA/ALUSrcB/ResultSrc/ImmSrc codes.
REQ-028 ALUControl and illegal funct3 decoding SHALL live in sub-module alu_decoder (inputs ALUOp, op[5], funct3, funct7b5).

Verification
REQ-029 Reset, then lw (op=0000011, funct3=010): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
REQ-030 R-type sub (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECR; R-type slt (funct3=010): ALUControl=101.
REQ-031 beq with zero=1, then beq with zero=0: PCWrite=1 in the BEQ cycle for the first, 0 for the second; both take 3 cycles.
REQ-032 op=1111111 in DECODE: illegal=1 for one cycle, next state FETCH, no write enable asserted.
REQ-033 Assert reset during MEMWRITE: MemWrite drops to 0 without waiting for clk; after release, FETCH outputs appear with IRWrite=1.
REQ-034 jal with MULTICYCLE_CONTROL_JAL_EN defined: states JAL then ALUWB. Same stimulus with the macro undefined: illegal pulse, back to FETCH.
